// File: rtl/game_pkg.sv
// Shared definitions for the goose runner game controller: state encodings,
// screen geometry and a counter-width helper.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HIT  = 2'd2,
    ST_OVER = 2'd3
  } game_state_e;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;

  // Bits needed to hold every value in 0..max_val (at least one).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Button conditioner: two-flop synchronizer followed by a registered
// rising-edge detector. Emits a single one-clock pulse per press, however
// long the button is held. Shared by start and steering buttons.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic sync1_q, sync2_q, prev_q, pulse_q;

  // Synchronize the raw button and register the 0->1 edge of the clean copy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pulse_q <= sync2_q & ~prev_q;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/game_ctrl.sv
// Per-frame game controller: frame tick generation, goose/bean collision
// latch, game state machine (idle/run/hit/over) and score keeping.
// Optional feature macro: GAME_HISCORE_EN keeps a best-score register that
// is updated on each RUN->HIT transition; without it hiscore is tied to 0.
module game_ctrl
  import game_pkg::*;
#(
  parameter int unsigned SCORE_W          = 10,
  parameter int unsigned FRAMES_PER_POINT = 60,
  parameter int unsigned HIT_FRAMES       = 30
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               video_on,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  input  logic               goose,
  input  logic               bean,
  input  logic               btn_start,
  output logic [1:0]         state,
  output logic               run,
  output logic               game_over,
  output logic               hit_flash,
  output logic               frame_tick,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] hiscore
);

  localparam int unsigned FRAME_W = cnt_width(FRAMES_PER_POINT - 1);
  // hit_cnt[2:0] drives the flash cadence, so keep at least three bits.
  localparam int unsigned HIT_W   = (cnt_width(HIT_FRAMES) < 3) ? 3 : cnt_width(HIT_FRAMES);

  logic               vblank_start;
  logic               vblank_q;
  logic               frame_tick_q;
  logic               hit_pend_q;
  logic               start_p;

  game_state_e        state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [HIT_W-1:0]   hit_cnt_q, hit_cnt_d, hit_cnt_inc;
  logic               hit_flash_q, hit_flash_d;

  assign vblank_start = (y == 10'(V_ACTIVE)) && (x == 10'd0);
  assign hit_cnt_inc  = hit_cnt_q + HIT_W'(1);

  btn_edge u_start (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_start),
    .pulse (start_p)
  );

  // One-clock frame pulse on the first clock vblank_start is seen; the
  // pixel position is held for several clocks, hence the edge detect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vblank_q     <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      vblank_q     <= vblank_start;
      frame_tick_q <= vblank_start & ~vblank_q;
    end
  end

  // Sticky per-frame overlap flag; the frame tick clear takes priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_pend_q <= 1'b0;
    end else if (frame_tick_q) begin
      hit_pend_q <= 1'b0;
    end else if (video_on && goose && bean) begin
      hit_pend_q <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_OVER: if (start_p) state_d = ST_RUN;
      ST_RUN:           if (frame_tick_q && hit_pend_q) state_d = ST_HIT;
      ST_HIT: begin
        if (frame_tick_q && (hit_cnt_q == HIT_W'(HIT_FRAMES - 1))) state_d = ST_OVER;
      end
      default:          state_d = ST_IDLE;
    endcase
  end

  // FSM outputs decoded straight from the state register.
  always_comb begin
    state     = state_q;
    run       = (state_q == ST_RUN);
    game_over = (state_q == ST_OVER);
  end

  // Score, frame and hit counters advanced per state on the qualifying event.
  always_comb begin
    score_d     = score_q;
    frame_cnt_d = frame_cnt_q;
    hit_cnt_d   = hit_cnt_q;
    hit_flash_d = hit_flash_q;
    unique case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_p) begin
          score_d     = '0;
          frame_cnt_d = '0;
          hit_cnt_d   = '0;
          hit_flash_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (frame_tick_q) begin
          if (hit_pend_q) begin
            // A hit frame never scores.
            hit_cnt_d   = '0;
            hit_flash_d = 1'b0;
          end else if (frame_cnt_q == FRAME_W'(FRAMES_PER_POINT - 1)) begin
            frame_cnt_d = '0;
            if (score_q != {SCORE_W{1'b1}}) score_d = score_q + SCORE_W'(1);
          end else begin
            frame_cnt_d = frame_cnt_q + FRAME_W'(1);
          end
        end
      end
      ST_HIT: begin
        if (frame_tick_q) begin
          hit_cnt_d = hit_cnt_inc;
          if (hit_cnt_inc[2:0] == 3'd0) hit_flash_d = ~hit_flash_q;
          if (hit_cnt_q == HIT_W'(HIT_FRAMES - 1)) hit_flash_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Counter and flash registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score_q     <= '0;
      frame_cnt_q <= '0;
      hit_cnt_q   <= '0;
      hit_flash_q <= 1'b0;
    end else begin
      score_q     <= score_d;
      frame_cnt_q <= frame_cnt_d;
      hit_cnt_q   <= hit_cnt_d;
      hit_flash_q <= hit_flash_d;
    end
  end

  assign frame_tick = frame_tick_q;
  assign hit_flash  = hit_flash_q;
  assign score      = score_q;

`ifdef GAME_HISCORE_EN
  logic               enter_hit;
  logic [SCORE_W-1:0] hiscore_q;

  assign enter_hit = (state_q == ST_RUN) && frame_tick_q && hit_pend_q;

  // Best score captured as each game ends; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hiscore_q <= '0;
    end else if (enter_hit && (score_q > hiscore_q)) begin
      hiscore_q <= score_q;
    end
  end

  assign hiscore = hiscore_q;
`else
  assign hiscore = '0;
`endif

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: short synthetic frames with random pixel
// content, compared against a frame-level model of the game rules.
module tb_game_ctrl;

  localparam int FPP  = 60;
  localparam int HF   = 30;
  localparam int MAXS = 1023;
`ifdef GAME_HISCORE_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       video_on = 1'b0, goose = 1'b0, bean = 1'b0, btn_start = 1'b0;
  logic [9:0] x = '0, y = '0;
  logic [1:0] state;
  logic       run, game_over, hit_flash, frame_tick;
  logic [9:0] score, hiscore;

  int total = 0, bad = 0;
  int tick_cnt = 0, wide_cnt = 0, start_cnt = 0;
  logic prev_tick = 1'b0;

  // Model: 0 idle, 1 run, 2 hit, 3 over.
  int m_state = 0, m_survived = 0, m_hits = 0, m_hi = 0;

  game_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .video_on   (video_on),
    .x          (x),
    .y          (y),
    .goose      (goose),
    .bean       (bean),
    .btn_start  (btn_start),
    .state      (state),
    .run        (run),
    .game_over  (game_over),
    .hit_flash  (hit_flash),
    .frame_tick (frame_tick),
    .score      (score),
    .hiscore    (hiscore)
  );

  always #5 clk = ~clk;

  // Count frame pulses, multi-clock pulses and start pulses.
  always @(negedge clk) begin
    if (frame_tick === 1'b1) begin
      tick_cnt++;
      if (prev_tick === 1'b1) wide_cnt++;
    end
    prev_tick = frame_tick;
    if (dut.u_start.pulse === 1'b1) start_cnt++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int m_score();
    int s;
    s = m_survived / FPP;
    return (s > MAXS) ? MAXS : s;
  endfunction

  function automatic logic m_flash();
    return (m_state == 2) ? logic'((m_hits >> 3) & 1) : 1'b0;
  endfunction

  task automatic model_start();
    if (m_state == 0 || m_state == 3) begin
      m_state    = 1;
      m_survived = 0;
      m_hits     = 0;
    end
  endtask

  task automatic model_frame(input bit ovl);
    if (m_state == 1) begin
      if (ovl) begin
        if (HI_EN && m_score() > m_hi) m_hi = m_score();
        m_state = 2;
        m_hits  = 0;
      end else begin
        m_survived++;
      end
    end else if (m_state == 2) begin
      m_hits++;
      if (m_hits == HF) m_state = 3;
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_pix(input logic v, input logic [9:0] px, input logic [9:0] py,
                           input logic g, input logic b);
    video_on = v; x = px; y = py; goose = g; bean = b;
    step(4);
  endtask

  // One short frame: four active pixels, a blanking overlap that must be
  // ignored, then the vblank start held for a full pixel time.
  task automatic do_frame(input bit ovl);
    int   k;
    logic g, b;
    k = $urandom_range(0, 3);
    for (int i = 0; i < 4; i++) begin
      if (ovl && i == k) begin
        drive_pix(1'b1, 10'd100, 10'd200, 1'b1, 1'b1);
      end else begin
        g = 1'($urandom_range(0, 1));
        b = ~g & 1'($urandom_range(0, 1));
        drive_pix(1'b1, 10'($urandom_range(0, 639)), 10'($urandom_range(0, 479)), g, b);
      end
    end
    drive_pix(1'b0, 10'd700, 10'($urandom_range(0, 479)), 1'b1, 1'b1);
    drive_pix(1'b0, 10'd0, 10'd480, 1'b0, 1'b0);
    drive_pix(1'b0, 10'd1, 10'd480, 1'b0, 1'b0);
    model_frame(ovl);
  endtask

  task automatic press_start(input int hold);
    btn_start = 1'b1;
    step(hold);
    btn_start = 1'b0;
    step(4);
    model_start();
  endtask

  task automatic test_reset();
    step(3);
    total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state); end
    total++; if (run !== 1'b0 || game_over !== 1'b0) begin bad++; $display("FAIL reset_flags: run=%b over=%b want 0 0", run, game_over); end
    total++; if (hit_flash !== 1'b0 || frame_tick !== 1'b0) begin bad++; $display("FAIL reset_flash_tick: flash=%b tick=%b want 0 0", hit_flash, frame_tick); end
    total++; if (score !== 10'd0 || hiscore !== 10'd0) begin bad++; $display("FAIL reset_scores: score=%0d hi=%0d want 0 0", score, hiscore); end
    reset = 1'b0;
    step(2);
    total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_release_state: got %0d want 0", state); end
  endtask

  task automatic test_start_hold();
    int s0;
    s0 = start_cnt;
    btn_start = 1'b1;
    step(3);
    total++; if (state !== 2'd0) begin bad++; $display("FAIL start_early: got %0d want 0", state); end
    step(1);
    total++; if (state !== 2'd1 || run !== 1'b1) begin bad++; $display("FAIL start_4clk: state=%0d run=%b want 1 1", state, run); end
    step(996);
    btn_start = 1'b0;
    step(4);
    model_start();
    total++; if (start_cnt - s0 !== 1) begin bad++; $display("FAIL start_single_pulse: got %0d want 1", start_cnt - s0); end
    total++; if (state !== 2'd1 || score !== 10'd0) begin bad++; $display("FAIL start_hold_state: state=%0d score=%0d want 1 0", state, score); end
  endtask

  task automatic test_score_frames();
    int t0, w0, sbad;
    t0 = tick_cnt; w0 = wide_cnt; sbad = 0;
    for (int i = 0; i < 120; i++) begin
      do_frame(1'b0);
      total++;
      if (state !== 2'(m_state) || score !== 10'(m_score())) begin
        bad++;
        $display("FAIL score_frame%0d: state=%0d score=%0d want %0d %0d", i, state, score, m_state, m_score());
      end
    end
    total++; if (score !== 10'd2) begin bad++; $display("FAIL score_120: got %0d want 2", score); end
    total++; if (tick_cnt - t0 !== 120) begin bad++; $display("FAIL tick_count: got %0d want 120", tick_cnt - t0); end
    total++; if (wide_cnt - w0 !== 0) begin bad++; $display("FAIL tick_width: wide=%0d want 0", wide_cnt - w0); end
  endtask

  task automatic test_hit_on_last();
    for (int i = 0; i < FPP - 1; i++) do_frame(1'b0);
    total++; if (score !== 10'd2 || state !== 2'd1) begin bad++; $display("FAIL pre_hit: score=%0d state=%0d want 2 1", score, state); end
    do_frame(1'b1);
    total++; if (state !== 2'd2 || run !== 1'b0) begin bad++; $display("FAIL hit_enter: state=%0d run=%b want 2 0", state, run); end
    total++; if (score !== 10'd2) begin bad++; $display("FAIL hit_no_point: got %0d want 2", score); end
  endtask

  task automatic test_hit_sequence();
    for (int i = 0; i < HF; i++) begin
      if (i == 12) press_start(8);
      do_frame(1'($urandom_range(0, 1)));
      total++;
      if (state !== 2'(m_state) || hit_flash !== m_flash()) begin
        bad++;
        $display("FAIL hit_tick%0d: state=%0d flash=%b want %0d %b", i + 1, state, hit_flash, m_state, m_flash());
      end
    end
    total++; if (state !== 2'd3 || game_over !== 1'b1) begin bad++; $display("FAIL over: state=%0d over=%b want 3 1", state, game_over); end
    total++; if (hit_flash !== 1'b0 || run !== 1'b0) begin bad++; $display("FAIL over_flags: flash=%b run=%b want 0 0", hit_flash, run); end
    total++; if (score !== 10'd2) begin bad++; $display("FAIL over_score: got %0d want 2", score); end
  endtask

  task automatic test_hiscore();
    int want_hi;
    press_start(5);
    total++; if (state !== 2'd1 || score !== 10'd0) begin bad++; $display("FAIL restart: state=%0d score=%0d want 1 0", state, score); end
    for (int i = 0; i < 7 * FPP; i++) do_frame(1'b0);
    total++; if (score !== 10'd7) begin bad++; $display("FAIL game1_score: got %0d want 7", score); end
    do_frame(1'b1);
    for (int i = 0; i < HF; i++) do_frame(1'b0);
    press_start(6);
    for (int i = 0; i < 3 * FPP; i++) do_frame(1'b0);
    total++; if (score !== 10'd3) begin bad++; $display("FAIL game2_score: got %0d want 3", score); end
    do_frame(1'b1);
    for (int i = 0; i < HF; i++) do_frame(1'b0);
    want_hi = HI_EN ? 7 : 0;
    total++; if (hiscore !== 10'(m_hi) || m_hi != want_hi) begin bad++; $display("FAIL hiscore: got %0d want %0d", hiscore, want_hi); end
    total++; if (game_over !== 1'b1) begin bad++; $display("FAIL game2_over: got %b want 1", game_over); end
  endtask

  task automatic test_reset_mid_run();
    press_start(4);
    for (int i = 0; i < 5 * FPP; i++) do_frame(1'b0);
    total++; if (score !== 10'd5 || state !== 2'd1) begin bad++; $display("FAIL mid_run_pre: score=%0d state=%0d want 5 1", score, state); end
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    total++; if (state !== 2'd0 || run !== 1'b0) begin bad++; $display("FAIL async_reset_state: state=%0d run=%b want 0 0", state, run); end
    total++; if (score !== 10'd0 || hiscore !== 10'd0) begin bad++; $display("FAIL async_reset_score: score=%0d hi=%0d want 0 0", score, hiscore); end
    m_state = 0; m_survived = 0; m_hits = 0; m_hi = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) do_frame(1'b0);
    total++; if (state !== 2'd0 || score !== 10'd0) begin bad++; $display("FAIL post_reset_idle: state=%0d score=%0d want 0 0", state, score); end
  endtask

  task automatic test_random();
    bit ovl;
    for (int i = 0; i < 250; i++) begin
      if ((m_state == 0 || m_state == 3) && $urandom_range(0, 2) == 0) press_start($urandom_range(4, 12));
      else if (m_state == 2 && $urandom_range(0, 7) == 0) press_start($urandom_range(4, 12));
      ovl = (m_state == 1) ? ($urandom_range(0, 29) == 0) : 1'($urandom_range(0, 1));
      do_frame(ovl);
      total++;
      if (state !== 2'(m_state) || score !== 10'(m_score()) || hit_flash !== m_flash() ||
          run !== (m_state == 1) || game_over !== (m_state == 3) || hiscore !== 10'(m_hi)) begin
        bad++;
        $display("FAIL random%0d: st=%0d sc=%0d fl=%b run=%b ov=%b hi=%0d want st=%0d sc=%0d fl=%b hi=%0d",
                 i, state, score, hit_flash, run, game_over, hiscore, m_state, m_score(), m_flash(), m_hi);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start_hold();
    test_score_frames();
    test_hit_on_last();
    test_hit_sequence();
    test_hiscore();
    test_reset_mid_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
